// File: rtl/cu_pkg.sv
// Shared types for the ALU control unit: opcodes, ALU operation codes (shared with the ALU),
// FSM state encoding and the decoded-instruction record.
package cu_pkg;

    localparam int OPC_W    = 4;
    localparam int ALU_OP_W = 3;

    localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OPC_LDAC = 4'h1;
    localparam logic [OPC_W-1:0] OPC_STAC = 4'h2;
    localparam logic [OPC_W-1:0] OPC_ADD  = 4'h3;
    localparam logic [OPC_W-1:0] OPC_SUB  = 4'h4;
    localparam logic [OPC_W-1:0] OPC_MUL  = 4'h5;
    localparam logic [OPC_W-1:0] OPC_INC  = 4'h6;
    localparam logic [OPC_W-1:0] OPC_CLAC = 4'h7;
    localparam logic [OPC_W-1:0] OPC_JUMP = 4'h8;
    localparam logic [OPC_W-1:0] OPC_JMPZ = 4'h9;
    localparam logic [OPC_W-1:0] OPC_JPNZ = 4'hA;
    localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_IDLE = 3'b000,
        ALU_PASS = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_SUB  = 3'b011,
        ALU_MUL  = 3'b100,
        ALU_INC  = 3'b101,
        ALU_ZERO = 3'b110
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_OPERAND = 3'd3,
        ST_EXEC    = 3'd4,
        ST_STORE   = 3'd5,
        ST_HALT    = 3'd6
    } state_e;

    typedef struct packed {
        logic    needs_operand;
        logic    is_store;
        logic    is_jump;
        logic    is_halt;
        logic    is_illegal;
        alu_op_e exec_alu_op;
    } decode_t;

endpackage

// File: rtl/alu_control_unit_if.sv
// Control-unit <-> datapath/memory bundle. master = control unit, slave = datapath side.
interface alu_control_unit_if #(
    parameter int OPC_W    = cu_pkg::OPC_W,
    parameter int ALU_OP_W = cu_pkg::ALU_OP_W
);
    logic [OPC_W-1:0]    opcode;
    logic                zflag;
    logic                mem_ready;
    logic [ALU_OP_W-1:0] alu_op;
    logic                ac_load;
    logic                ir_load;
    logic                dr_load;
    logic                pc_inc;
    logic                pc_load;
    logic                addr_sel;
    logic                mem_read;
    logic                mem_write;
    logic                z_latched;
    logic                halted;
    logic                illegal;

    modport master (
        input  opcode, zflag, mem_ready,
        output alu_op, ac_load, ir_load, dr_load, pc_inc, pc_load, addr_sel,
               mem_read, mem_write, z_latched, halted, illegal
    );

    modport slave (
        output opcode, zflag, mem_ready,
        input  alu_op, ac_load, ir_load, dr_load, pc_inc, pc_load, addr_sel,
               mem_read, mem_write, z_latched, halted, illegal
    );
endinterface

// File: rtl/cu_opcode_decode.sv
// Purely combinational opcode classifier; zero latency, no handshake.
module cu_opcode_decode
    import cu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output decode_t          dec
);

    always_comb begin
        dec             = '0;
        dec.exec_alu_op = ALU_IDLE;
        case (opcode)
            OPC_NOP:  ;
            OPC_LDAC: begin dec.needs_operand = 1'b1; dec.exec_alu_op = ALU_PASS; end
            OPC_STAC: dec.is_store = 1'b1;
            OPC_ADD:  begin dec.needs_operand = 1'b1; dec.exec_alu_op = ALU_ADD;  end
            OPC_SUB:  begin dec.needs_operand = 1'b1; dec.exec_alu_op = ALU_SUB;  end
            OPC_MUL:  begin dec.needs_operand = 1'b1; dec.exec_alu_op = ALU_MUL;  end
            OPC_INC:  dec.exec_alu_op = ALU_INC;
            OPC_CLAC: dec.exec_alu_op = ALU_ZERO;
            OPC_JUMP, OPC_JMPZ, OPC_JPNZ: dec.is_jump = 1'b1;
            OPC_HALT: dec.is_halt = 1'b1;
            default:  dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control_unit.sv
// Multi-cycle fetch/decode/operand/exec/store sequencer for the 12-bit ALU; memory phases stall on mem_ready.
// Define CU_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT with a sticky illegal flag (else they act as NOP).
module alu_control_unit
    import cu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    alu_control_unit_if.master bus
);

    state_e  state;
    state_e  state_nxt;
    decode_t dec;
    logic    z_q;

    alu_op_e alu_op_c;
    logic    ac_load_c, ir_load_c, dr_load_c, pc_inc_c, pc_load_c;
    logic    addr_sel_c, mem_read_c, mem_write_c, halted_c;

    cu_opcode_decode u_decode (
        .opcode (bus.opcode),
        .dec    (dec)
    );

`ifdef CU_ILLEGAL_TRAP_EN
    logic ill_q;
    logic ill_set;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_START;
            z_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            // Only SUB produces a zero flag worth keeping for JMPZ/JPNZ.
            if (state == ST_EXEC && dec.exec_alu_op == ALU_SUB) begin
                z_q <= bus.zflag;
            end
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ill_q <= 1'b0;
        end else if (ill_set) begin
            ill_q <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt   = state;
        alu_op_c    = ALU_IDLE;
        ac_load_c   = 1'b0;
        ir_load_c   = 1'b0;
        dr_load_c   = 1'b0;
        pc_inc_c    = 1'b0;
        pc_load_c   = 1'b0;
        addr_sel_c  = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        halted_c    = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
        ill_set     = 1'b0;
`endif
        case (state)
            ST_START: state_nxt = ST_FETCH;
            ST_FETCH: begin
                mem_read_c = 1'b1;
                if (bus.mem_ready) begin
                    ir_load_c = 1'b1;
                    pc_inc_c  = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec.is_halt) begin
                    state_nxt = ST_HALT;
                end else if (dec.is_illegal) begin
`ifdef CU_ILLEGAL_TRAP_EN
                    ill_set   = 1'b1;
                    state_nxt = ST_HALT;
`else
                    state_nxt = ST_FETCH;
`endif
                end else if (dec.needs_operand) begin
                    state_nxt = ST_OPERAND;
                end else if (dec.is_store) begin
                    state_nxt = ST_STORE;
                end else if (dec.is_jump) begin
                    case (bus.opcode)
                        OPC_JMPZ: pc_load_c = z_q;
                        OPC_JPNZ: pc_load_c = ~z_q;
                        default:  pc_load_c = 1'b1;
                    endcase
                    state_nxt = ST_FETCH;
                end else if (dec.exec_alu_op != ALU_IDLE) begin
                    state_nxt = ST_EXEC;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_OPERAND: begin
                mem_read_c = 1'b1;
                addr_sel_c = 1'b1;
                if (bus.mem_ready) begin
                    dr_load_c = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ac_load_c = 1'b1;
                alu_op_c  = dec.exec_alu_op;
                state_nxt = ST_FETCH;
            end
            ST_STORE: begin
                mem_write_c = 1'b1;
                addr_sel_c  = 1'b1;
                if (bus.mem_ready) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALT:  halted_c  = 1'b1;
            default:  state_nxt = ST_START;
        endcase
    end

    assign bus.alu_op    = alu_op_c;
    assign bus.ac_load   = ac_load_c;
    assign bus.ir_load   = ir_load_c;
    assign bus.dr_load   = dr_load_c;
    assign bus.pc_inc    = pc_inc_c;
    assign bus.pc_load   = pc_load_c;
    assign bus.addr_sel  = addr_sel_c;
    assign bus.mem_read  = mem_read_c;
    assign bus.mem_write = mem_write_c;
    assign bus.z_latched = z_q;
    assign bus.halted    = halted_c;
`ifdef CU_ILLEGAL_TRAP_EN
    assign bus.illegal   = ill_q;
`else
    assign bus.illegal   = 1'b0;
`endif

endmodule
